// File: rtl/blk_accum_pkg.sv
// Shared types, default geometry and width helpers for the block luminance accumulator.
package blk_accum_pkg;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_HP = 1920;
    localparam int unsigned DEF_VP = 1080;
    localparam int unsigned DEF_KH = 30;
    localparam int unsigned DEF_KV = 30;

    // Bits needed to hold a block sum up to max_sum.
    function automatic int unsigned sum_width(input int unsigned max_sum);
        return $clog2(max_sum + 1);
    endfunction

    // Bits needed for a counter over n states (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/blk_flag_mem.sv
// Per-block previous dark/bright flags for the hysteresis decision (BLK_ACCUM_HYST_EN builds).
module blk_flag_mem #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [IW-1:0] idx_i,
    input  logic          we_i,
    input  logic          flag_i,
    output logic          prev_dark_c
);

    logic [N-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[idx_i] = flag_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) mem_q <= '0;
        else         mem_q <= mem_d;
    end

    assign prev_dark_c = mem_q[idx_i];

endmodule

// File: rtl/blk_accum.sv
// Block luminance accumulator: sums gray per KHxKV block and flags dark blocks.
// Optional sticky decision with BLK_ACCUM_HYST_EN.
module blk_accum
    import blk_accum_pkg::*;
#(
    parameter int unsigned HP    = DEF_HP,
    parameter int unsigned VP    = DEF_VP,
    parameter int unsigned KH    = DEF_KH,
    parameter int unsigned KV    = DEF_KV,
    parameter int unsigned HBLKS = (HP + KH - 1) / KH,
    parameter int unsigned VBLKS = (VP + KV - 1) / KV,
    parameter int unsigned MAX   = KH * KV * 255,
    parameter int unsigned HYST  = KH * KV * 16,
    localparam int unsigned SW   = sum_width(MAX)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          vs_i,
    input  logic          de_i,
    input  logic [7:0]    gray_i,
    output logic          blk_valid_o,
    output logic          blk_dark_o,
    output logic [31:0]   blk_ht_o,
    output logic [31:0]   blk_vt_o,
    output logic [SW-1:0] blk_sum_o,
    output logic          frame_done_o
);

    localparam int unsigned CW = cnt_width(KH);
    localparam int unsigned LW = cnt_width(KV);
    localparam int unsigned HW = cnt_width(HBLKS);
    localparam int unsigned VW = cnt_width(VBLKS);
    localparam int unsigned YW = cnt_width(VP);

    state_e         state_q, state_d;
    logic           vs_q, vs_d, de_q, de_d;
    logic [CW-1:0]  col_q, col_d;
    logic [LW-1:0]  lin_q, lin_d;
    logic [HW-1:0]  hb_q, hb_d;
    logic [VW-1:0]  vb_q, vb_d;
    logic [YW-1:0]  line_q, line_d;
    logic [SW-1:0]  acc_q [2**HW];
    logic [SW-1:0]  acc_d [2**HW];
    logic           blk_valid_q, blk_valid_d, blk_dark_q, blk_dark_d;
    logic [31:0]    blk_ht_q, blk_ht_d, blk_vt_q, blk_vt_d;
    logic [SW-1:0]  blk_sum_q, blk_sum_d;
    logic           frame_done_q, frame_done_d;

    logic           vs_rise, de_fall, last_row, close_c, dark_c;
    logic [SW:0]    acc_sum, two_sum;
    logic [SW-1:0]  acc_sat, close_sum;

`ifdef BLK_ACCUM_HYST_EN
    localparam int unsigned NB = HBLKS * VBLKS;
    localparam int unsigned IW = cnt_width(NB);
    localparam logic [63:0] TH_LO = (MAX > 2 * HYST) ? 64'(MAX - 2 * HYST) : 64'(0);
    localparam logic [63:0] TH_HI = 64'(MAX) + 64'(2 * HYST);

    logic [IW-1:0] mem_idx;
    logic          prev_dark_c;

    assign mem_idx = IW'(vb_q) * IW'(HBLKS) + IW'(hb_q);

    blk_flag_mem #(.N(NB), .IW(IW)) u_flag_mem (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .idx_i       (mem_idx),
        .we_i        (close_c),
        .flag_i      (dark_c),
        .prev_dark_c (prev_dark_c)
    );
`endif

    // Next-state, counters, accumulators and result registers.
    always_comb begin
        state_d      = state_q;
        vs_d         = vs_i;
        de_d         = de_i;
        col_d        = col_q;
        lin_d        = lin_q;
        hb_d         = hb_q;
        vb_d         = vb_q;
        line_d       = line_q;
        acc_d        = acc_q;
        blk_valid_d  = 1'b0;
        blk_dark_d   = blk_dark_q;
        blk_ht_d     = blk_ht_q;
        blk_vt_d     = blk_vt_q;
        blk_sum_d    = blk_sum_q;
        frame_done_d = blk_valid_q && (blk_ht_q == 32'(HBLKS - 1))
                                   && (blk_vt_q == 32'(VBLKS - 1));
        vs_rise      = vs_i & ~vs_q;
        de_fall      = de_q & ~de_i;
        last_row     = (lin_q == LW'(KV - 1)) || (line_q == YW'(VP - 1));
        acc_sum      = {1'b0, acc_q[hb_q]} + (SW + 1)'(gray_i);
        acc_sat      = acc_sum[SW] ? '1 : acc_sum[SW-1:0];
        close_c      = 1'b0;
        close_sum    = acc_q[hb_q];

        if (vs_rise) begin
            // Frame start: discard everything in flight, including a coincident pixel.
            state_d = ST_RUN;
            col_d   = '0;
            lin_d   = '0;
            hb_d    = '0;
            vb_d    = '0;
            line_d  = '0;
            acc_d   = '{default: '0};
        end else if (state_q == ST_RUN) begin
            if (de_i) begin
                acc_d[hb_q] = acc_sat;
                if (col_q == CW'(KH - 1)) begin
                    col_d = '0;
                    if (hb_q != HW'(HBLKS - 1)) hb_d = hb_q + 1'b1;
                    if (last_row) begin
                        close_c   = 1'b1;
                        close_sum = acc_sat;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else if (de_fall) begin
                col_d  = '0;
                hb_d   = '0;
                line_d = (line_q == YW'(VP - 1)) ? '0 : line_q + 1'b1;
                if (last_row) begin
                    lin_d = '0;
                    vb_d  = (vb_q == VW'(VBLKS - 1)) ? '0 : vb_q + 1'b1;
                end else begin
                    lin_d = lin_q + 1'b1;
                end
                // A partial edge block ends at the line end rather than at a full column.
                if (last_row && (col_q != '0)) close_c = 1'b1;
            end
        end

        two_sum = {close_sum, 1'b0};
`ifdef BLK_ACCUM_HYST_EN
        dark_c = prev_dark_c ? (64'(two_sum) < TH_HI) : (64'(two_sum) < TH_LO);
`else
        dark_c = two_sum < (SW + 1)'(MAX);
`endif

        if (close_c) begin
            acc_d[hb_q] = '0;
            blk_valid_d = 1'b1;
            blk_dark_d  = dark_c;
            blk_ht_d    = 32'(hb_q);
            blk_vt_d    = 32'(vb_q);
            blk_sum_d   = close_sum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_WAIT;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            col_q        <= '0;
            lin_q        <= '0;
            hb_q         <= '0;
            vb_q         <= '0;
            line_q       <= '0;
            acc_q        <= '{default: '0};
            blk_valid_q  <= 1'b0;
            blk_dark_q   <= 1'b0;
            blk_ht_q     <= '0;
            blk_vt_q     <= '0;
            blk_sum_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_d;
            de_q         <= de_d;
            col_q        <= col_d;
            lin_q        <= lin_d;
            hb_q         <= hb_d;
            vb_q         <= vb_d;
            line_q       <= line_d;
            acc_q        <= acc_d;
            blk_valid_q  <= blk_valid_d;
            blk_dark_q   <= blk_dark_d;
            blk_ht_q     <= blk_ht_d;
            blk_vt_q     <= blk_vt_d;
            blk_sum_q    <= blk_sum_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign blk_valid_o  = blk_valid_q;
    assign blk_dark_o   = blk_dark_q;
    assign blk_ht_o     = blk_ht_q;
    assign blk_vt_o     = blk_vt_q;
    assign blk_sum_o    = blk_sum_q;
    assign frame_done_o = frame_done_q;

endmodule
